// File: rtl/dds_sample_sequencer.sv
// dds_sample_sequencer: voice configuration registers, sample-rate divider and
// the IDLE/SEND0/SEND1 arbiter that shares one SPI DAC serializer between two voices.
// Optional build macro DDS_SEQ_SWEEP_EN: adds a signed per-tick sweep of tune0
// (step written via addresses 7/8); without it those addresses are ignored.
module dds_sample_sequencer #(
    parameter int TUNE_W      = 16,
    parameter int WAVE_W      = 12,
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 63
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [7:0]        cfg_wdata,
    output logic [1:0]        voice_ce,
    output logic [TUNE_W-1:0] tune0,
    output logic [TUNE_W-1:0] tune1,
    output logic [2:0]        sel0,
    output logic [2:0]        sel1,
    input  logic [WAVE_W-1:0] wave0_in,
    input  logic [WAVE_W-1:0] wave1_in,
    output logic [15:0]       dac_data,
    output logic              dac_valid,
    input  logic              dac_ready,
    output logic [7:0]        overrun_cnt
);
    typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

    // zero padding between the channel bit and the sample in the DAC word
    localparam int PAD_W = 15 - WAVE_W;

    state_t             state;
    logic [7:0]         t0_lo, t1_lo;
    logic [DIV_W-1:0]   div, cnt;
    logic               run, mono, xfer_mono;
    logic [WAVE_W-1:0]  buf1;
    logic               tick, tick_acc, ovr_clr, div_we;
`ifdef DDS_SEQ_SWEEP_EN
    logic [7:0]         sw_lo;
    logic [TUNE_W-1:0]  step;
`endif

    assign tick     = run && (cnt == div);
    assign tick_acc = tick && (state == IDLE);
    assign div_we   = cfg_we && (cfg_addr == 4'd5);
    assign ovr_clr  = cfg_we && (cfg_addr == 4'd6) && cfg_wdata[2];

    // Config register file; tuning words commit atomically on the HI byte write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            t0_lo <= '0;
            t1_lo <= '0;
            tune0 <= '0;
            tune1 <= '0;
            sel0  <= '0;
            sel1  <= '0;
            div   <= DIV_W'(DIV_DEFAULT);
            run   <= 1'b0;
            mono  <= 1'b0;
`ifdef DDS_SEQ_SWEEP_EN
            sw_lo <= '0;
            step  <= '0;
`endif
        end else begin
            if (cfg_we) begin
                case (cfg_addr)
                    4'd0: t0_lo <= cfg_wdata;
                    4'd2: t1_lo <= cfg_wdata;
                    4'd3: tune1 <= TUNE_W'({cfg_wdata, t1_lo});
                    4'd4: begin
                        sel0 <= cfg_wdata[2:0];
                        sel1 <= cfg_wdata[5:3];
                    end
                    4'd5: div <= DIV_W'(cfg_wdata);
                    4'd6: begin
                        run  <= cfg_wdata[0];
                        mono <= cfg_wdata[1];
                    end
`ifdef DDS_SEQ_SWEEP_EN
                    4'd7: sw_lo <= cfg_wdata;
                    4'd8: step  <= TUNE_W'({cfg_wdata, sw_lo});
`endif
                    default: ;
                endcase
            end
            // an explicit T0_HI write wins over the sweep step in the same cycle
            if (cfg_we && (cfg_addr == 4'd1))
                tune0 <= TUNE_W'({cfg_wdata, t0_lo});
`ifdef DDS_SEQ_SWEEP_EN
            else if (tick_acc)
                tune0 <= tune0 + step;
`endif
        end
    end

    // Sample-rate divider: counts 0..div, held at 0 while stopped, restarted by a DIV write
    always_ff @(posedge clk) begin
        if (!rst_n || div_we || !run || tick)
            cnt <= '0;
        else
            cnt <= cnt + DIV_W'(1);
    end

    // DAC arbiter; voice 0 goes straight into dac_data, voice 1 waits in buf1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            buf1      <= '0;
            xfer_mono <= 1'b0;
            dac_valid <= 1'b0;
            dac_data  <= '0;
            voice_ce  <= 2'b00;
        end else begin
            voice_ce <= 2'b00;
            case (state)
                IDLE: if (tick) begin
                    buf1      <= wave1_in;
                    xfer_mono <= mono;  // a transfer finishes in the mode it started in
                    voice_ce  <= mono ? 2'b01 : 2'b11;
                    dac_valid <= 1'b1;
                    dac_data  <= {1'b0, {PAD_W{1'b0}}, wave0_in};
                    state     <= SEND0;
                end
                SEND0: if (dac_ready) begin
                    if (xfer_mono) begin
                        dac_valid <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        dac_data <= {1'b1, {PAD_W{1'b0}}, buf1};
                        state    <= SEND1;
                    end
                end
                SEND1: if (dac_ready) begin
                    dac_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    dac_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Dropped-tick counter, saturating; a clear beats a simultaneous increment
    always_ff @(posedge clk) begin
        if (!rst_n || ovr_clr)
            overrun_cnt <= '0;
        else if (tick && (state != IDLE) && (overrun_cnt != 8'hFF))
            overrun_cnt <= overrun_cnt + 8'd1;
    end
endmodule

// File: tb/tb_dds_sample_sequencer.sv
// tb_dds_sample_sequencer: scenario tasks plus a negedge reference model that
// pushes expected DAC words on every accepted tick and pops them on handshakes.
module tb_dds_sample_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [7:0]  cfg_wdata = '0;
    logic [1:0]  voice_ce;
    logic [15:0] tune0, tune1;
    logic [2:0]  sel0, sel1;
    logic [11:0] wave0_in = '0, wave1_in = '0;
    logic [15:0] dac_data;
    logic        dac_valid;
    logic        dac_ready = 1'b0;
    logic [7:0]  overrun_cnt;

    int n_cmp = 0;
    int n_err = 0;

    dds_sample_sequencer dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .voice_ce(voice_ce), .tune0(tune0), .tune1(tune1), .sel0(sel0), .sel1(sel1),
        .wave0_in(wave0_in), .wave1_in(wave1_in), .dac_data(dac_data), .dac_valid(dac_valid),
        .dac_ready(dac_ready), .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    // reference model state (values the DUT should show after the last edge)
    logic [15:0] sb[$];
    logic [7:0]  m_div, m_cnt, m_ovr;
    logic        m_run, m_mono, m_xm, m_tk;
    logic [1:0]  m_ce;
    int          m_st;
    logic [15:0] m_exp;

    // check current outputs against the model, then advance the model over the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if (dac_valid !== (m_st != 0)) begin
                n_err++;
                $display("FAIL mon_valid: got %b want %b", dac_valid, (m_st != 0));
            end
            n_cmp++;
            if (voice_ce !== m_ce) begin
                n_err++;
                $display("FAIL mon_ce: got %b want %b", voice_ce, m_ce);
            end
            n_cmp++;
            if (overrun_cnt !== m_ovr) begin
                n_err++;
                $display("FAIL mon_ovr: got %0d want %0d", overrun_cnt, m_ovr);
            end
            if (dac_valid && dac_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_word: got %h want none", dac_data);
                end else begin
                    m_exp = sb.pop_front();
                    if (dac_data !== m_exp) begin
                        n_err++;
                        $display("FAIL sb_word: got %h want %h", dac_data, m_exp);
                    end
                end
            end
        end
        if (!rst_n) begin
            m_div = 8'd63; m_cnt = 0; m_ovr = 0; m_run = 0; m_mono = 0; m_xm = 0;
            m_ce = 0; m_st = 0;
            sb.delete();
        end else begin
            m_tk = m_run && (m_cnt == m_div);
            m_ce = 2'b00;
            if (m_tk && m_st != 0 && m_ovr != 8'hFF) m_ovr = m_ovr + 1;
            case (m_st)
                0: if (m_tk) begin
                    sb.push_back({4'h0, wave0_in});
                    if (!m_mono) sb.push_back({4'h8, wave1_in});
                    m_xm = m_mono;
                    m_ce = m_mono ? 2'b01 : 2'b11;
                    m_st = 1;
                end
                1: if (dac_ready) m_st = m_xm ? 0 : 2;
                default: if (dac_ready) m_st = 0;
            endcase
            if (cfg_we && cfg_addr == 4'd6 && cfg_wdata[2]) m_ovr = 0;
            if ((cfg_we && cfg_addr == 4'd5) || !m_run || m_tk) m_cnt = 0;
            else m_cnt = m_cnt + 1;
            if (cfg_we && cfg_addr == 4'd5) m_div = cfg_wdata;
            if (cfg_we && cfg_addr == 4'd6) begin
                m_run = cfg_wdata[0];
                m_mono = cfg_wdata[1];
            end
        end
    end

    task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
        @(posedge clk); #2;
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk); #2;
        cfg_we = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // wait (bounded) for the next voice_ce pulse, starting one cycle later
    task automatic wait_ce(input string tag);
        int k = 0;
        cycles(1);
        while (voice_ce == 2'b00 && k < 300) begin
            cycles(1);
            k++;
        end
        if (k >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: got no voice_ce want pulse", tag);
        end
    endtask

    task automatic drain(input string tag);
        cfg_wr(4'd6, 8'h00);
        dac_ready = 1'b1;
        cycles(10);
        n_cmp++;
        if (sb.size() != 0 || dac_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_drain: got %0d pending valid=%b want 0 pending", tag, sb.size(), dac_valid);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        n_cmp++;
        if ({voice_ce, tune0, tune1, sel0, sel1, dac_data, dac_valid, overrun_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_outs: got ce=%b t0=%h t1=%h s=%0d/%0d d=%h v=%b o=%0d want all 0",
                     voice_ce, tune0, tune1, sel0, sel1, dac_data, dac_valid, overrun_cnt);
        end
    endtask

    task automatic test_config;
        cfg_wr(4'd0, 8'h34);
        n_cmp++;
        if (tune0 !== 16'h0000) begin n_err++; $display("FAIL t0_lo_only: got %h want 0000", tune0); end
        cfg_wr(4'd1, 8'h12);
        n_cmp++;
        if (tune0 !== 16'h1234) begin n_err++; $display("FAIL t0_commit: got %h want 1234", tune0); end
        cfg_wr(4'd2, 8'hCD);
        cfg_wr(4'd3, 8'hAB);
        n_cmp++;
        if (tune1 !== 16'hABCD) begin n_err++; $display("FAIL t1_commit: got %h want abcd", tune1); end
        cfg_wr(4'd4, 8'b00_101_011);
        n_cmp++;
        if (sel0 !== 3'd3 || sel1 !== 3'd5) begin
            n_err++; $display("FAIL sel: got %0d/%0d want 3/5", sel0, sel1);
        end
        cfg_wr(4'd12, 8'hFF);
        n_cmp++;
        if (tune0 !== 16'h1234 || tune1 !== 16'hABCD || sel0 !== 3'd3) begin
            n_err++; $display("FAIL unmapped: got t0=%h t1=%h s0=%0d want 1234 abcd 3", tune0, tune1, sel0);
        end
    endtask

    task automatic test_stream;
        int n3 = 0, n1 = 0;
        wave0_in = 12'h0AB; wave1_in = 12'hFFF; dac_ready = 1'b1;
        cfg_wr(4'd5, 8'd3);
        cfg_wr(4'd6, 8'h01);
        wait_ce("stream");
        n_cmp++;
        if (dac_data !== 16'h00AB) begin n_err++; $display("FAIL stream_w0: got %h want 00ab", dac_data); end
        cycles(1);
        n_cmp++;
        if (dac_data !== 16'h8FFF || dac_valid !== 1'b1) begin
            n_err++; $display("FAIL stream_w1: got %h v=%b want 8fff v=1", dac_data, dac_valid);
        end
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (voice_ce == 2'b11) n3++;
            if (voice_ce == 2'b01) n1++;
        end
        n_cmp++;
        if (n3 != 10 || n1 != 0) begin n_err++; $display("FAIL stream_ce: got %0d/%0d want 10/0", n3, n1); end
        drain("stream");
    endtask

    task automatic test_mono;
        int n1 = 0, n3 = 0, ch1 = 0;
        wave0_in = 12'h123; wave1_in = 12'h456;
        cfg_wr(4'd6, 8'h03);
        for (int i = 0; i < 40; i++) begin
            cycles(1);
            if (voice_ce == 2'b01) n1++;
            if (voice_ce == 2'b11) n3++;
            if (dac_valid && dac_data[15]) ch1++;
        end
        n_cmp++;
        if (n1 != 10 || n3 != 0 || ch1 != 0) begin
            n_err++; $display("FAIL mono: got ce01=%0d ce11=%0d ch1=%0d want 10 0 0", n1, n3, ch1);
        end
        drain("mono");
    endtask

    task automatic test_overrun;
        logic [15:0] held;
        int k = 0, changes = 0;
        cfg_wr(4'd6, 8'h04);
        dac_ready = 1'b0; wave0_in = 12'h5A5; wave1_in = 12'h3C3;
        cfg_wr(4'd5, 8'd3);
        cfg_wr(4'd6, 8'h01);
        while (!dac_valid && k < 50) begin cycles(1); k++; end
        held = dac_data;
        for (int i = 0; i < 20; i++) begin
            cycles(1);
            wave0_in = wave0_in + 12'h011;
            if (dac_data !== held || !dac_valid) changes++;
        end
        n_cmp++;
        if (changes != 0 || held !== 16'h05A5) begin
            n_err++; $display("FAIL ovr_hold: got %h changes=%0d want 05a5 0", held, changes);
        end
        n_cmp++;
        if (overrun_cnt !== m_ovr || overrun_cnt < 8'd4) begin
            n_err++; $display("FAIL ovr_count: got %0d want %0d", overrun_cnt, m_ovr);
        end
        drain("ovr");
        cfg_wr(4'd6, 8'h04);
        n_cmp++;
        if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL ovr_clear: got %0d want 0", overrun_cnt); end
    endtask

    task automatic test_saturate;
        dac_ready = 1'b0;
        cfg_wr(4'd5, 8'd0);
        cfg_wr(4'd6, 8'h01);
        cycles(300);
        n_cmp++;
        if (overrun_cnt !== 8'hFF) begin n_err++; $display("FAIL ovr_sat: got %0d want 255", overrun_cnt); end
        cfg_wr(4'd6, 8'h05);
        n_cmp++;
        if (overrun_cnt !== 8'd0) begin n_err++; $display("FAIL clr_prio: got %0d want 0", overrun_cnt); end
        cycles(1);
        n_cmp++;
        if (overrun_cnt !== 8'd1) begin n_err++; $display("FAIL clr_resume: got %0d want 1", overrun_cnt); end
        drain("sat");
        cfg_wr(4'd6, 8'h04);
    endtask

    task automatic test_div0;
        dac_ready = 1'b1; wave0_in = 12'h00F; wave1_in = 12'h0F0;
        cfg_wr(4'd5, 8'd0);
        cfg_wr(4'd6, 8'h01);
        cycles(15);
        n_cmp++;
        if (overrun_cnt !== m_ovr || overrun_cnt == 8'd0) begin
            n_err++; $display("FAIL div0_drop: got %0d want %0d", overrun_cnt, m_ovr);
        end
        drain("div0");
        cfg_wr(4'd6, 8'h04);
    endtask

    task automatic test_reset_send1;
        int k = 0, per = 0;
        dac_ready = 1'b0;
        cfg_wr(4'd5, 8'd3);
        cfg_wr(4'd6, 8'h01);
        while (!dac_valid && k < 50) begin cycles(1); k++; end
        dac_ready = 1'b1;
        cycles(1);
        n_cmp++;
        if (dac_valid !== 1'b1 || dac_data[15] !== 1'b1) begin
            n_err++; $display("FAIL rst_pre_send1: got v=%b d=%h want v=1 ch1", dac_valid, dac_data);
        end
        dac_ready = 1'b0; rst_n = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        n_cmp++;
        if ({voice_ce, tune0, tune1, sel0, sel1, dac_data, dac_valid, overrun_cnt} !== '0) begin
            n_err++; $display("FAIL rst_send1: got v=%b d=%h t0=%h o=%0d want all 0",
                              dac_valid, dac_data, tune0, overrun_cnt);
        end
        dac_ready = 1'b1;
        cfg_wr(4'd6, 8'h01);
        wait_ce("rst_div");
        cycles(1);
        per = 1;
        while (voice_ce == 2'b00 && per < 200) begin cycles(1); per++; end
        n_cmp++;
        if (per != 64) begin n_err++; $display("FAIL rst_div: got period %0d want 64", per); end
        drain("rst");
    endtask

`ifdef DDS_SEQ_SWEEP_EN
    task automatic test_sweep;
        dac_ready = 1'b1;
        cfg_wr(4'd7, 8'hF0);
        cfg_wr(4'd8, 8'hFF);
        cfg_wr(4'd0, 8'h00);
        cfg_wr(4'd1, 8'h01);
        n_cmp++;
        if (tune0 !== 16'h0100) begin n_err++; $display("FAIL sw_init: got %h want 0100", tune0); end
        cfg_wr(4'd5, 8'd3);
        cfg_wr(4'd6, 8'h01);
        wait_ce("sweep");
        wait_ce("sweep");
        wait_ce("sweep");
        cfg_wr(4'd6, 8'h00);
        cycles(6);
        n_cmp++;
        if (tune0 !== 16'h00D0) begin n_err++; $display("FAIL sw_3ticks: got %h want 00d0", tune0); end
        drain("sweep");
        cfg_wr(4'd0, 8'h00);
        cfg_wr(4'd1, 8'h00);
        cfg_wr(4'd6, 8'h01);
        wait_ce("sweep_wrap");
        cfg_wr(4'd6, 8'h00);
        cycles(6);
        n_cmp++;
        if (tune0 !== 16'hFFF0) begin n_err++; $display("FAIL sw_wrap: got %h want fff0", tune0); end
        drain("sweep_wrap");
    endtask
`endif

    initial begin
        test_reset();
        test_config();
        test_stream();
        test_mono();
        test_overrun();
        test_saturate();
        test_div0();
        test_reset_send1();
`ifdef DDS_SEQ_SWEEP_EN
        test_sweep();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
